// File: rtl/pc_seq_ctrl_pkg.sv
// Shared encodings for the PC sequencing controller: PC update types,
// controller states and the bundle of registered outputs.
package pc_seq_ctrl_pkg;

  localparam logic [1:0] PC_ADDR_NORMAL = 2'b00;
  localparam logic [1:0] PC_ADDR_BRANCH = 2'b01;
  localparam logic [1:0] PC_ADDR_JUMP   = 2'b10;
  localparam logic [1:0] PC_ADDR_UNUSED = 2'b11;

  localparam logic [1:0] SEQ_IDLE   = 2'd0;
  localparam logic [1:0] SEQ_RUN    = 2'd1;
  localparam logic [1:0] SEQ_WAIT   = 2'd2;
  localparam logic [1:0] SEQ_COMMIT = 2'd3;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] inc_type;
    logic       take;
    logic       fetch_valid;
    logic       flush;
    logic       err_timeout;
  } seq_out_t;

  localparam seq_out_t SEQ_OUT_RST = '{
    pc_en:       1'b0,
    inc_type:    PC_ADDR_NORMAL,
    take:        1'b0,
    fetch_valid: 1'b0,
    flush:       1'b0,
    err_timeout: 1'b0
  };

  // Only branches and jumps need an ALU resolution; UNUSED behaves as NORMAL.
  function automatic logic is_redirect(input logic [1:0] addr_type);
    return (addr_type == PC_ADDR_BRANCH) || (addr_type == PC_ADDR_JUMP);
  endfunction

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Bundle between decode/ALU/PC and the sequencing controller.
interface pc_seq_ctrl_if #(
  parameter int CNT_W = 16
) ();

  logic             stall;
  logic             decode_valid;
  logic [1:0]       decode_type;
  logic             res_valid;
  logic             res_taken;
  logic             pc_en;
  logic [1:0]       pc_inc_type;
  logic             pc_take;
  logic             fetch_valid;
  logic             flush;
  logic             err_timeout;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] tk_cnt;

  modport master (
    output stall, decode_valid, decode_type, res_valid, res_taken,
    input  pc_en, pc_inc_type, pc_take, fetch_valid, flush, err_timeout,
    input  br_cnt, tk_cnt
  );

  modport slave (
    input  stall, decode_valid, decode_type, res_valid, res_taken,
    output pc_en, pc_inc_type, pc_take, fetch_valid, flush, err_timeout,
    output br_cnt, tk_cnt
  );

endinterface

// File: rtl/pc_seq_ctrl_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
module pc_seq_ctrl_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC sequencing controller: gates PC updates, freezes fetch while a branch or
// jump awaits ALU resolution, and keeps saturating branch statistics.
module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_seq_ctrl_if.slave  bus
);

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       type_q, type_d;
  logic [7:0]       timer_q, timer_d;
  seq_out_t         out_q, out_d;
  logic             br_inc, tk_inc;
  logic [CNT_W-1:0] br_cnt, tk_cnt;

  // Outputs are registered with the state, so each state's decision becomes
  // visible in the following cycle, stable for the PC's falling-edge sample.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    timer_d = timer_q;
    out_d   = SEQ_OUT_RST;
    case (state_q)
      SEQ_IDLE: begin
        state_d = SEQ_RUN;
      end
      SEQ_RUN: begin
        if (!bus.stall) begin
          if (bus.decode_valid && is_redirect(bus.decode_type)) begin
            type_d  = bus.decode_type;
            timer_d = '0;
            state_d = SEQ_WAIT;
          end else begin
            out_d.pc_en       = 1'b1;
            out_d.fetch_valid = 1'b1;
          end
        end
      end
      SEQ_WAIT: begin
        if (bus.res_valid) begin
          out_d.pc_en    = 1'b1;
          out_d.inc_type = type_q;
          out_d.take     = bus.res_taken;
          out_d.flush    = bus.res_taken;
          state_d        = SEQ_COMMIT;
        end else if (timer_q == TIMER_LAST) begin
          out_d.pc_en       = 1'b1;
          out_d.inc_type    = type_q;
          out_d.err_timeout = 1'b1;
          state_d           = SEQ_COMMIT;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      SEQ_COMMIT: begin
        // The cycle after commit is already a RUN cycle, so stall applies.
        state_d = SEQ_RUN;
        if (!bus.stall) begin
          out_d.pc_en       = 1'b1;
          out_d.fetch_valid = 1'b1;
        end
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ_IDLE;
      type_q  <= PC_ADDR_NORMAL;
      timer_q <= '0;
      out_q   <= SEQ_OUT_RST;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      timer_q <= timer_d;
      out_q   <= out_d;
    end
  end

  assign br_inc = (state_q == SEQ_COMMIT);
  assign tk_inc = br_inc && out_q.take;

  pc_seq_ctrl_sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (br_inc),
    .count (br_cnt)
  );

  pc_seq_ctrl_sat_counter #(.W(CNT_W)) u_tk_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tk_inc),
    .count (tk_cnt)
  );

  assign bus.pc_en       = out_q.pc_en;
  assign bus.pc_inc_type = out_q.inc_type;
  assign bus.pc_take     = out_q.take;
  assign bus.fetch_valid = out_q.fetch_valid;
  assign bus.flush       = out_q.flush;
  assign bus.err_timeout = out_q.err_timeout;
  assign bus.br_cnt      = br_cnt;
  assign bus.tk_cnt      = tk_cnt;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: directed vector table, hand-written
// timeout/saturation/reset sequences and random traffic against a reference model.
module tb_pc_seq_ctrl;

  localparam int TIMEOUT = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  pc_seq_ctrl_if #(.CNT_W(16)) bus ();
  pc_seq_ctrl_if #(.CNT_W(2))  bus2 ();

  pc_seq_ctrl #(.CNT_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pc_seq_ctrl #(.CNT_W(2), .TIMEOUT(TIMEOUT)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: a pending redirect with a running wait count, a commit
  // flag, and unbounded totals that are clamped only when compared.
  bit       m_booted, m_waiting, m_committing, m_commit_take;
  int       m_waited;
  bit [1:0] m_latched;
  int       br_total, tk_total;
  bit       e_pc_en, e_take, e_fv, e_fl, e_er;
  bit [1:0] e_typ;

  typedef struct {
    bit       s;  bit dv; bit [1:0] dt; bit rv; bit rt;
    bit       pc_en; bit [1:0] typ; bit take; bit fv; bit fl; bit er;
    int       br; int tk;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(bit s, bit dv, bit [1:0] dt, bit rv, bit rt,
                              bit pc_en, bit [1:0] typ, bit take, bit fv,
                              bit fl, bit er, int br, int tk);
    vec_t v;
    v.s = s; v.dv = dv; v.dt = dt; v.rv = rv; v.rt = rt;
    v.pc_en = pc_en; v.typ = typ; v.take = take; v.fv = fv;
    v.fl = fl; v.er = er; v.br = br; v.tk = tk;
    return v;
  endfunction

  function automatic int sat(int v, int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic modelReset();
    m_booted = 0; m_waiting = 0; m_committing = 0; m_commit_take = 0;
    m_waited = 0; m_latched = 2'b00;
    br_total = 0; tk_total = 0;
    e_pc_en = 0; e_typ = 2'b00; e_take = 0; e_fv = 0; e_fl = 0; e_er = 0;
  endtask

  task automatic modelStep(input bit s, input bit dv, input bit [1:0] dt,
                           input bit rv, input bit rt);
    e_pc_en = 0; e_typ = 2'b00; e_take = 0; e_fv = 0; e_fl = 0; e_er = 0;
    if (!m_booted) begin
      m_booted = 1;
    end else if (m_committing) begin
      m_committing = 0;
      br_total++;
      if (m_commit_take) tk_total++;
      if (!s) begin e_pc_en = 1; e_fv = 1; end
    end else if (m_waiting) begin
      m_waited++;
      if (rv || m_waited == TIMEOUT) begin
        m_waiting     = 0;
        m_committing  = 1;
        m_commit_take = rv && rt;
        e_pc_en = 1; e_typ = m_latched; e_take = m_commit_take;
        e_fl = m_commit_take; e_er = !rv;
      end
    end else if (!s) begin
      if (dv && (dt == 2'b01 || dt == 2'b10)) begin
        m_waiting = 1; m_waited = 0; m_latched = dt;
      end else begin
        e_pc_en = 1; e_fv = 1;
      end
    end
  endtask

  task automatic checkOutput();
    cmp("pc_en",       32'(bus.pc_en),       32'(e_pc_en));
    cmp("pc_inc_type", 32'(bus.pc_inc_type), 32'(e_typ));
    cmp("pc_take",     32'(bus.pc_take),     32'(e_take));
    cmp("fetch_valid", 32'(bus.fetch_valid), 32'(e_fv));
    cmp("flush",       32'(bus.flush),       32'(e_fl));
    cmp("err_timeout", 32'(bus.err_timeout), 32'(e_er));
    cmp("br_cnt",      32'(bus.br_cnt),      32'(sat(br_total, 16)));
    cmp("tk_cnt",      32'(bus.tk_cnt),      32'(sat(tk_total, 16)));
    cmp("br_cnt_w2",   32'(bus2.br_cnt),     32'(sat(br_total, 2)));
    cmp("tk_cnt_w2",   32'(bus2.tk_cnt),     32'(sat(tk_total, 2)));
  endtask

  task automatic driveInputs(input bit s, input bit dv, input bit [1:0] dt,
                             input bit rv, input bit rt);
    bus.stall = s;  bus.decode_valid = dv;  bus.decode_type = dt;
    bus.res_valid = rv;  bus.res_taken = rt;
    bus2.stall = s; bus2.decode_valid = dv; bus2.decode_type = dt;
    bus2.res_valid = rv; bus2.res_taken = rt;
  endtask

  task automatic applyStimulus(input bit s, input bit dv, input bit [1:0] dt,
                               input bit rv, input bit rt);
    driveInputs(s, dv, dt, rv, rt);
    @(posedge clk);
    cyc++;
    modelStep(s, dv, dt, rv, rt);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    driveInputs(0, 0, 2'b00, 0, 0);
    rst_n = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // s dv dt rv rt | pc_en typ take fv fl er | br tk
    tbl[0]  = mk(0,0,2'b00,0,0, 0,2'b00,0,0,0,0, 0,0);
    tbl[1]  = mk(0,0,2'b00,0,0, 1,2'b00,0,1,0,0, 0,0);
    tbl[2]  = mk(0,0,2'b00,0,0, 1,2'b00,0,1,0,0, 0,0);
    tbl[3]  = mk(0,0,2'b00,0,0, 1,2'b00,0,1,0,0, 0,0);
    tbl[4]  = mk(0,1,2'b01,0,0, 0,2'b00,0,0,0,0, 0,0);
    tbl[5]  = mk(0,0,2'b00,0,0, 0,2'b00,0,0,0,0, 0,0);
    tbl[6]  = mk(0,0,2'b00,1,1, 1,2'b01,1,0,1,0, 0,0);
    tbl[7]  = mk(0,0,2'b00,0,0, 1,2'b00,0,1,0,0, 1,1);
    tbl[8]  = mk(0,1,2'b10,0,0, 0,2'b00,0,0,0,0, 1,1);
    tbl[9]  = mk(0,0,2'b00,1,0, 1,2'b10,0,0,0,0, 1,1);
    tbl[10] = mk(0,0,2'b00,0,0, 1,2'b00,0,1,0,0, 2,1);
    tbl[11] = mk(0,0,2'b00,0,0, 1,2'b00,0,1,0,0, 2,1);
    tbl[12] = mk(1,0,2'b00,0,0, 0,2'b00,0,0,0,0, 2,1);
    tbl[13] = mk(1,0,2'b00,0,0, 0,2'b00,0,0,0,0, 2,1);
    tbl[14] = mk(1,1,2'b01,0,0, 0,2'b00,0,0,0,0, 2,1);
    tbl[15] = mk(0,1,2'b01,0,0, 0,2'b00,0,0,0,0, 2,1);
    tbl[16] = mk(0,0,2'b00,1,1, 1,2'b01,1,0,1,0, 2,1);
    tbl[17] = mk(1,0,2'b00,0,0, 0,2'b00,0,0,0,0, 3,2);
    tbl[18] = mk(0,0,2'b00,1,1, 1,2'b00,0,1,0,0, 3,2);
    tbl[19] = mk(0,1,2'b11,0,0, 1,2'b00,0,1,0,0, 3,2);

    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(tbl[i].s, tbl[i].dv, tbl[i].dt, tbl[i].rv, tbl[i].rt);
      cmp("tbl_pc_en",       32'(bus.pc_en),       32'(tbl[i].pc_en));
      cmp("tbl_pc_inc_type", 32'(bus.pc_inc_type), 32'(tbl[i].typ));
      cmp("tbl_pc_take",     32'(bus.pc_take),     32'(tbl[i].take));
      cmp("tbl_fetch_valid", 32'(bus.fetch_valid), 32'(tbl[i].fv));
      cmp("tbl_flush",       32'(bus.flush),       32'(tbl[i].fl));
      cmp("tbl_err_timeout", 32'(bus.err_timeout), 32'(tbl[i].er));
      cmp("tbl_br_cnt",      32'(bus.br_cnt),      32'(tbl[i].br));
      cmp("tbl_tk_cnt",      32'(bus.tk_cnt),      32'(tbl[i].tk));
    end

    // Timeout: stall/decode are driven during WAIT to show they are ignored.
    for (int rep = 0; rep < 2; rep++) begin
      int br_before;
      br_before = br_total;
      applyStimulus(0, 1, 2'b01, 0, 0);
      for (int k = 1; k <= TIMEOUT; k++) begin
        if (k < TIMEOUT) begin
          applyStimulus(1, 1, 2'b10, 0, 0);
          cmp("to_wait_pc_en", 32'(bus.pc_en), 32'd0);
          cmp("to_wait_err",   32'(bus.err_timeout), 32'd0);
        end else begin
          applyStimulus(0, 0, 2'b00, (rep == 1), (rep == 1));
          cmp("to_commit_pc_en", 32'(bus.pc_en), 32'd1);
          cmp("to_commit_type",  32'(bus.pc_inc_type), 32'd1);
          cmp("to_commit_err",   32'(bus.err_timeout), (rep == 0) ? 32'd1 : 32'd0);
          cmp("to_commit_take",  32'(bus.pc_take), (rep == 0) ? 32'd0 : 32'd1);
        end
      end
      applyStimulus(0, 0, 2'b00, 0, 0);
      cmp("to_after_err", 32'(bus.err_timeout), 32'd0);
      cmp("to_after_br",  32'(bus.br_cnt), 32'(br_before + 1));
    end

    // Five taken branches from reset: the 2-bit counters stop at 3.
    doReset();
    applyStimulus(0, 0, 2'b00, 0, 0);
    for (int b = 0; b < 5; b++) begin
      applyStimulus(0, 1, 2'b01, 0, 0);
      applyStimulus(0, 0, 2'b00, 1, 1);
      applyStimulus(0, 0, 2'b00, 0, 0);
    end
    cmp("sat_br_w2", 32'(bus2.br_cnt), 32'd3);
    cmp("sat_tk_w2", 32'(bus2.tk_cnt), 32'd3);
    cmp("sat_br_16", 32'(bus.br_cnt),  32'd5);
    cmp("sat_tk_16", 32'(bus.tk_cnt),  32'd5);

    // Reset in the middle of WAIT_RES: immediate clear and no later commit.
    applyStimulus(0, 1, 2'b10, 0, 0);
    applyStimulus(0, 0, 2'b00, 0, 0);
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 0, 2'b00, 1, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 2'b00, 1, 1);
    cmp("rst_no_commit_br", 32'(bus.br_cnt), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bit s, dv, rv, rt;
      bit [1:0] dt;
      s  = ($urandom_range(3) == 0);
      dv = 1'($urandom_range(1));
      dt = 2'($urandom_range(3));
      rv = ($urandom_range(5) == 0);
      rt = 1'($urandom_range(1));
      applyStimulus(s, dv, dt, rv, rt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Sequencing controller for the program counter register.
- Decides each cycle whether the PC advances, and with which update type (PC_ADDR_NORMAL / BRANCH / JUMP) and taken bit.
- Freezes fetch while a decoded branch or jump waits for its ALU resolution, which may take several cycles.
- Keeps saturating branch statistics and flags resolution timeouts. Sits between decode, the ALU branch result and the PC.

Parameters:
- CNT_W, 16, width of the branch/taken statistics counters
- TIMEOUT, 15, max cycles in WAIT_RES before a forced not-taken commit (1..255)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  downstream hazard; hold the PC while in RUN
- decode_valid  input  1  decode_type is valid this cycle
- decode_type  input  2  PC_ADDR_* encoding of the decoded instruction
- res_valid  input  1  ALU branch resolution available
- res_taken  input  1  ALU branch result (1 = taken)
- pc_en  output  1  PC may update at the next falling edge
- pc_inc_type  output  2  PC update type presented to the PC
- pc_take  output  1  taken bit presented to the PC (alu_branch_result)
- fetch_valid  output  1  fetched instruction at the current PC is valid
- flush  output  1  one-cycle pulse; discard the in-flight fetch after a taken redirect
- err_timeout  output  1  one-cycle pulse on forced commit
- br_cnt  output  CNT_W  resolved branch/jump count
- tk_cnt  output  CNT_W  taken count

Behaviour:
- Clock and reset: all state and outputs are registered on the rising edge of clk. The PC samples them on the falling edge, so outputs are stable at that edge.
- Reset (rst_n=0, async): state=IDLE; pc_en=0, pc_inc_type=PC_ADDR_NORMAL, pc_take=0, fetch_valid=0, flush=0, err_timeout=0, br_cnt=0, tk_cnt=0, timer=0. A reset mid-WAIT_RES discards the latched type; there is no commit.
- The PC holds its value whenever pc_en=0. This gate is added in the PC update path.
- IDLE: one cycle with outputs at reset values, then RUN.
- RUN, stall=1: pc_en=0, fetch_valid=0. Stay in RUN. decode_valid is ignored.
- RUN, stall=0, decode_valid=1, decode_type is BRANCH or JUMP:
  - latch the type; timer=0; go to WAIT_RES.
  - pc_en=0, fetch_valid=0.
- RUN, otherwise: pc_en=1, pc_inc_type=PC_ADDR_NORMAL, pc_take=0, fetch_valid=1. decode_type PC_ADDR_UNUSED is treated as NORMAL.
- WAIT_RES: pc_en=0, fetch_valid=0; stall and decode_valid are ignored. Each cycle:
  - if res_valid: register pc_take=res_taken, pc_inc_type=latched type, pc_en=1; go to COMMIT.
  - else if timer==TIMEOUT-1: pc_take=0, pc_inc_type=latched type, pc_en=1, err_timeout=1 for one cycle; go to COMMIT.
  - else timer++.
  - If res_valid arrives in the timeout cycle, res_valid wins and err_timeout is not asserted.
- COMMIT (exactly one cycle):
  - pc_en=1 with the registered type and take, so the PC updates at this falling edge.
  - fetch_valid=0; flush=pc_take.
  - br_cnt+=1; tk_cnt+=1 if pc_take. Both counters saturate at 2^CNT_W-1.
  - Next state is RUN. The first RUN cycle obeys the normal RUN rules, including stall.
- Latency:
  - branch decode to first redirected fetch_valid = resolution cycles + 2.
  - with res_valid present in the first WAIT_RES cycle, that is 3 cycles.
- res_valid outside WAIT_RES is ignored.
- A timeout commit counts in br_cnt, not in tk_cnt.

Decomposition:
- Shared defines file (existing): PC_ADDR_NORMAL/BRANCH/JUMP/UNUSED encodings.
- Add the state encodings there: SEQ_IDLE, SEQ_RUN, SEQ_WAIT, SEQ_COMMIT (2-bit).
- One natural sub-module: sat_counter (CNT_W-wide saturating incrementer with enable and async active-low reset), instantiated twice for br_cnt and tk_cnt.

Test Plan:
- Reset then 4 cycles with no decode:
  - IDLE for 1 cycle, then pc_en=1, type=00, fetch_valid=1 on each of the next 3 cycles.
  - br_cnt=0.
- BRANCH decode, res_valid=1/res_taken=1 two cycles later:
  - 2 WAIT cycles with pc_en=0.
  - COMMIT with pc_en=1, type=01, pc_take=1, flush=1.
  - br_cnt=1, tk_cnt=1.
- JUMP decode, res_taken=0 after 1 cycle:
  - COMMIT with type=10, pc_take=0, flush=0.
  - tk_cnt unchanged; RUN resumes with type=00.
- BRANCH decode, no res_valid:
  - forced commit after exactly 15 WAIT cycles; err_timeout pulses 1 cycle; pc_take=0; br_cnt+1.
  - Repeat with res_valid=1 in cycle 15: no err_timeout.
- stall=1 for 3 RUN cycles, then a BRANCH decode arrives while stall=1:
  - pc_en=0, fetch_valid=0 for those 3 cycles.
  - the BRANCH is not latched; it is latched in the first stall=0 cycle.
- Saturation and reset:
  - CNT_W=2: 5 taken branches leave br_cnt=tk_cnt=3.
  - rst_n low during WAIT_RES: all outputs return to reset values immediately, with no commit afterwards.
